// File: rtl/seg_scroll_rom.sv
// seg_scroll_rom: scrolling message engine for a DIGITS-wide seven-segment display.
// It holds a writable character buffer and a 32-entry active-low segment ROM.
// An offset sequencer scrolls the message left or right on a divided tick,
// or one step per rising edge of Step when in manual mode.
//
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   En                      0 blanks every digit and freezes the sequencer
//   Mode[1:0]               00 auto-left, 01 auto-right, 10 manual, 11 hold
//   Step                    manual step request; a rising edge steps once
//   Msg_Len[AW:0]           active length; 0 or > MSG_LEN means MSG_LEN
//   Wr_En/Wr_Addr/Wr_Char   buffer write port (out-of-range addresses ignored)
//   Seg_Out[7*DIGITS-1:0]   registered gfedcba, active-low; digit 0 in the top 7 bits
//   Offset[AW-1:0]          current scroll offset
//   Wrap_Pulse              one cycle after a step that wraps the offset

// Per-digit lane: picks buffer[(base + LANE) mod len], decodes it and registers the segments.
module seg_scroll_lane #(
  parameter int MSG_LEN = 16,
  parameter int AW      = 4,
  parameter int DIGITS  = 4,
  parameter int LANE    = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    en_i,
  input  logic [AW-1:0]           base_i,  // already guaranteed < len_i
  input  logic [AW:0]             len_i,   // 1..MSG_LEN
  input  logic [MSG_LEN-1:0][4:0] buf_i,
  output logic [6:0]              seg_o
);
  // Headroom so that base + LANE cannot overflow before reduction.
  localparam int IW = AW + 4;

  logic [IW-1:0] idx;
  logic [4:0]    chr;
  logic [6:0]    seg_d, seg_q;

  function automatic logic [6:0] rom(input logic [4:0] c);
    case (c)
      5'd1:  rom = 7'b0001000; // A
      5'd2:  rom = 7'b0000011; // B
      5'd3:  rom = 7'b1000110; // C
      5'd4:  rom = 7'b0100001; // D
      5'd5:  rom = 7'b0000110; // E
      5'd6:  rom = 7'b0001110; // F
      5'd7:  rom = 7'b0010000; // G
      5'd8:  rom = 7'b0001011; // H
      5'd9:  rom = 7'b1111001; // I
      5'd10: rom = 7'b1110001; // J
      5'd11: rom = 7'b0001001; // K
      5'd12: rom = 7'b1000111; // L
      5'd13: rom = 7'b1001000; // M
      5'd14: rom = 7'b0101011; // N
      5'd15: rom = 7'b0101010; // N-tilde
      5'd16: rom = 7'b1000000; // O
      5'd17: rom = 7'b0001100; // P
      5'd18: rom = 7'b0011000; // Q
      5'd19: rom = 7'b0101111; // R
      5'd20: rom = 7'b0010010; // S
      5'd21: rom = 7'b0000111; // T
      5'd22: rom = 7'b1100011; // U
      5'd23: rom = 7'b1000001; // V
      5'd24: rom = 7'b0110000; // W
      5'd25: rom = 7'b0000101; // X
      5'd26: rom = 7'b0010001; // Y
      5'd27: rom = 7'b0100100; // Z
      default: rom = 7'b1111111; // space: 0 and 28..31
    endcase
  endfunction

  // The index is at most len-1 + DIGITS-1. With len >= 1, DIGITS conditional
  // subtractions always reduce it into range, so no divider is needed.
  always_comb begin
    idx = IW'(base_i) + IW'(LANE);
    for (int k = 0; k < DIGITS; k++)
      if (idx >= IW'(len_i)) idx = idx - IW'(len_i);
    chr   = buf_i[idx[AW-1:0]];
    seg_d = en_i ? rom(chr) : 7'h7F;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) seg_q <= 7'h7F;
    else          seg_q <= seg_d;

  assign seg_o = seg_q;
endmodule

module seg_scroll_rom #(
  parameter  int DIGITS   = 4,
  parameter  int MSG_LEN  = 16,
  parameter  int TICK_DIV = 50_000_000,
  localparam int AW       = $clog2(MSG_LEN)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  En,
  input  logic [1:0]            Mode,
  input  logic                  Step,
  input  logic [AW:0]           Msg_Len,
  input  logic                  Wr_En,
  input  logic [AW-1:0]         Wr_Addr,
  input  logic [4:0]            Wr_Char,
  output logic [7*DIGITS-1:0]   Seg_Out,
  output logic [AW-1:0]         Offset,
  output logic                  Wrap_Pulse
);
  localparam int          CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [AW:0] MAXL = (AW+1)'(MSG_LEN);

  logic [MSG_LEN-1:0][4:0] buf_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           off_q, off_d, off_inc, off_dec, base;
  logic                    wrap_q, wrap_d, step_q;
  logic [AW:0]             len, len_m1;
  logic                    run, tick, over, last, step_edge;
  logic [DIGITS-1:0][6:0]  seg;

  assign len       = (Msg_Len == '0 || Msg_Len > MAXL) ? MAXL : Msg_Len;
  assign len_m1    = len - 1'b1;
  assign over      = {1'b0, off_q} >= len;   // only after Msg_Len shrinks
  assign base      = over ? '0 : off_q;
  assign last      = {1'b0, off_q} == len_m1;
  assign off_inc   = last ? '0 : off_q + 1'b1;
  assign off_dec   = (off_q == '0) ? len_m1[AW-1:0] : off_q - 1'b1;
  assign step_edge = Step & ~step_q;

  assign run  = En && !Mode[1];
  assign tick = run && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d  = run ? (tick ? '0 : cnt_q + 1'b1) : '0;
    off_d  = off_q;
    wrap_d = 1'b0;
    if (over) off_d = '0;   // silent clamp beats any step
    else if (En) begin
      case (Mode)
        2'b00:   if (tick)      begin off_d = off_inc; wrap_d = last;          end
        2'b01:   if (tick)      begin off_d = off_dec; wrap_d = (off_q == '0); end
        2'b10:   if (step_edge) begin off_d = off_inc; wrap_d = last;          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt_q  <= '0;
      off_q  <= '0;
      wrap_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      off_q  <= off_d;
      wrap_q <= wrap_d;
      step_q <= Step;  // tracks in every mode so a held level never re-steps
    end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) buf_q <= '0;
    else if (Wr_En && ({1'b0, Wr_Addr} < MAXL)) buf_q[Wr_Addr] <= Wr_Char;

  for (genvar d = 0; d < DIGITS; d++) begin : g_lane
    seg_scroll_lane #(.MSG_LEN(MSG_LEN), .AW(AW), .DIGITS(DIGITS), .LANE(d)) u_lane (
      .clock  (clock),
      .reset_n(reset_n),
      .en_i   (En),
      .base_i (base),
      .len_i  (len),
      .buf_i  (buf_q),
      .seg_o  (seg[DIGITS-1-d])   // digit 0 lands in the top slice
    );
  end

  assign Seg_Out    = seg;
  assign Offset     = off_q;
  assign Wrap_Pulse = wrap_q;
endmodule

// File: tb/tb_seg_scroll_rom.sv
// Directed bench for seg_scroll_rom: a 16-entry instance for scrolling behaviour
// and a 12-entry instance for out-of-range writes and the Msg_Len=0 length.
module tb_seg_scroll_rom;
  localparam logic [6:0] SP = 7'b1111111;
  localparam logic [6:0] H  = 7'b0001011;
  localparam logic [6:0] O  = 7'b1000000;
  localparam logic [6:0] L  = 7'b1000111;
  localparam logic [6:0] A  = 7'b0001000;
  localparam logic [27:0] ONES = '1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        En, Step, Wr_En;
  logic [1:0]  Mode;
  logic [4:0]  Msg_Len, Wr_Char;
  logic [3:0]  Wr_Addr, Offset;
  logic [27:0] Seg_Out;
  logic        Wrap_Pulse;

  logic        En2, Step2, Wr2_En;
  logic [1:0]  Mode2;
  logic [4:0]  Msg_Len2, Wr2_Char;
  logic [3:0]  Wr2_Addr, Offset2;
  logic [27:0] Seg2;
  logic        Wrap2;

  int n_cmp = 0;
  int n_bad = 0;
  int wraps;
  logic [27:0] rot [4];
  logic [4:0]  hola [4];

  seg_scroll_rom #(.DIGITS(4), .MSG_LEN(16), .TICK_DIV(4)) dut (
    .clock(clock), .reset_n(reset_n), .En(En), .Mode(Mode), .Step(Step),
    .Msg_Len(Msg_Len), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Char(Wr_Char),
    .Seg_Out(Seg_Out), .Offset(Offset), .Wrap_Pulse(Wrap_Pulse));

  seg_scroll_rom #(.DIGITS(4), .MSG_LEN(12), .TICK_DIV(4)) dut12 (
    .clock(clock), .reset_n(reset_n), .En(En2), .Mode(Mode2), .Step(Step2),
    .Msg_Len(Msg_Len2), .Wr_En(Wr2_En), .Wr_Addr(Wr2_Addr), .Wr_Char(Wr2_Char),
    .Seg_Out(Seg2), .Offset(Offset2), .Wrap_Pulse(Wrap2));

  always #5 clock = ~clock;

  task automatic edge1();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; En = 1'b1; Mode = 2'b10; Step = 1'b0; Msg_Len = 5'd4;
    Wr_En = 1'b0; Wr_Addr = '0; Wr_Char = '0;
    En2 = 1'b1; Mode2 = 2'b10; Step2 = 1'b0; Msg_Len2 = 5'd0;
    Wr2_En = 1'b0; Wr2_Addr = '0; Wr2_Char = '0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (Offset !== 4'd0) begin n_bad++; $display("FAIL reset_async_offset got=%0d want=0", Offset); end
    n_cmp++; if (Seg_Out !== ONES) begin n_bad++; $display("FAIL reset_async_seg got=%h want=%h", Seg_Out, ONES); end
    n_cmp++; if (Wrap_Pulse !== 1'b0) begin n_bad++; $display("FAIL reset_async_wrap got=%b want=0", Wrap_Pulse); end
    repeat (2) edge1();
    n_cmp++; if (Seg_Out !== ONES) begin n_bad++; $display("FAIL reset_held_seg got=%h want=%h", Seg_Out, ONES); end
    reset_n = 1'b1;
    edge1();
  endtask

  task automatic test_write_hola();
    for (int i = 0; i < 4; i++) begin
      Wr_En = 1'b1; Wr_Addr = 4'(i); Wr_Char = hola[i];
      edge1();
    end
    Wr_En = 1'b0;
    // display edge coinciding with the last write still sees a space in digit 3
    n_cmp++; if (Seg_Out !== {H, O, L, SP}) begin n_bad++; $display("FAIL write_latency got=%h want=%h", Seg_Out, {H, O, L, SP}); end
    edge1();
    n_cmp++; if (Seg_Out !== {H, O, L, A}) begin n_bad++; $display("FAIL write_hola got=%h want=%h", Seg_Out, {H, O, L, A}); end
  endtask

  task automatic test_auto_left();
    Mode = 2'b00; wraps = 0;
    for (int n = 1; n <= 17; n++) begin
      edge1();
      if (Wrap_Pulse === 1'b1) wraps++;
      if (n % 4 == 0) begin
        n_cmp++; if (Offset !== 4'((n / 4) % 4)) begin n_bad++; $display("FAIL left_offset n=%0d got=%0d want=%0d", n, Offset, (n / 4) % 4); end
        n_cmp++; if (Wrap_Pulse !== (n == 16)) begin n_bad++; $display("FAIL left_wrap n=%0d got=%b want=%b", n, Wrap_Pulse, n == 16); end
      end
      if (n % 4 == 1 && n > 1) begin
        n_cmp++; if (Seg_Out !== rot[(n / 4) % 4]) begin n_bad++; $display("FAIL left_seg n=%0d got=%h want=%h", n, Seg_Out, rot[(n / 4) % 4]); end
      end
    end
    n_cmp++; if (wraps !== 1) begin n_bad++; $display("FAIL left_wrap_count got=%0d want=1", wraps); end
    Mode = 2'b10;
    edge1();
  endtask

  task automatic test_auto_right();
    Mode = 2'b01;
    repeat (3) edge1();
    n_cmp++; if (Offset !== 4'd0) begin n_bad++; $display("FAIL right_early got=%0d want=0", Offset); end
    edge1();
    n_cmp++; if (Offset !== 4'd3) begin n_bad++; $display("FAIL right_offset got=%0d want=3", Offset); end
    n_cmp++; if (Wrap_Pulse !== 1'b1) begin n_bad++; $display("FAIL right_wrap got=%b want=1", Wrap_Pulse); end
    Mode = 2'b10;
    edge1();
    n_cmp++; if (Seg_Out !== rot[3]) begin n_bad++; $display("FAIL right_seg got=%h want=%h", Seg_Out, rot[3]); end
    n_cmp++; if (Wrap_Pulse !== 1'b0) begin n_bad++; $display("FAIL right_wrap_clear got=%b want=0", Wrap_Pulse); end
  endtask

  task automatic test_clamp();
    Msg_Len = 5'd2;
    edge1();
    n_cmp++; if (Offset !== 4'd0) begin n_bad++; $display("FAIL clamp_offset got=%0d want=0", Offset); end
    n_cmp++; if (Wrap_Pulse !== 1'b0) begin n_bad++; $display("FAIL clamp_wrap got=%b want=0", Wrap_Pulse); end
    edge1();
    n_cmp++; if (Seg_Out !== {H, O, H, O}) begin n_bad++; $display("FAIL clamp_seg got=%h want=%h", Seg_Out, {H, O, H, O}); end
  endtask

  task automatic test_manual();
    Step = 1'b1; wraps = 0;
    for (int n = 1; n <= 10; n++) begin
      edge1();
      if (Wrap_Pulse === 1'b1) wraps++;
      if (n == 1) begin
        n_cmp++; if (Offset !== 4'd1) begin n_bad++; $display("FAIL manual_first got=%0d want=1", Offset); end
      end
    end
    n_cmp++; if (Offset !== 4'd1) begin n_bad++; $display("FAIL manual_held got=%0d want=1", Offset); end
    n_cmp++; if (wraps !== 0) begin n_bad++; $display("FAIL manual_wrap_count got=%0d want=0", wraps); end
    Step = 1'b0; edge1();
    Step = 1'b1; edge1();
    n_cmp++; if (Offset !== 4'd0) begin n_bad++; $display("FAIL manual_wrap_offset got=%0d want=0", Offset); end
    n_cmp++; if (Wrap_Pulse !== 1'b1) begin n_bad++; $display("FAIL manual_wrap got=%b want=1", Wrap_Pulse); end
    Step = 1'b0; edge1();
  endtask

  task automatic test_len_one();
    Msg_Len = 5'd1; edge1();
    Step = 1'b1; edge1();
    n_cmp++; if (Offset !== 4'd0) begin n_bad++; $display("FAIL len1_offset got=%0d want=0", Offset); end
    n_cmp++; if (Wrap_Pulse !== 1'b1) begin n_bad++; $display("FAIL len1_wrap got=%b want=1", Wrap_Pulse); end
    Step = 1'b0; edge1();
    n_cmp++; if (Wrap_Pulse !== 1'b0) begin n_bad++; $display("FAIL len1_wrap_clear got=%b want=0", Wrap_Pulse); end
  endtask

  task automatic test_en_reset();
    Msg_Len = 5'd4; Mode = 2'b00;
    repeat (4) edge1();
    n_cmp++; if (Offset !== 4'd1) begin n_bad++; $display("FAIL en_pre_offset got=%0d want=1", Offset); end
    En = 1'b0; edge1();
    n_cmp++; if (Seg_Out !== ONES) begin n_bad++; $display("FAIL en_blank got=%h want=%h", Seg_Out, ONES); end
    repeat (8) edge1();
    n_cmp++; if (Offset !== 4'd1) begin n_bad++; $display("FAIL en_frozen got=%0d want=1", Offset); end
    n_cmp++; if (Seg_Out !== ONES) begin n_bad++; $display("FAIL en_blank_held got=%h want=%h", Seg_Out, ONES); end
    En = 1'b1; edge1();
    n_cmp++; if (Seg_Out !== rot[1]) begin n_bad++; $display("FAIL en_resume got=%h want=%h", Seg_Out, rot[1]); end
    reset_n = 1'b0; #1;
    n_cmp++; if (Offset !== 4'd0) begin n_bad++; $display("FAIL midreset_offset got=%0d want=0", Offset); end
    n_cmp++; if (Seg_Out !== ONES) begin n_bad++; $display("FAIL midreset_seg got=%h want=%h", Seg_Out, ONES); end
    edge1();
    reset_n = 1'b1; Mode = 2'b10;
    edge1();
    n_cmp++; if (Seg_Out !== ONES) begin n_bad++; $display("FAIL midreset_buf got=%h want=%h", Seg_Out, ONES); end
    Wr_En = 1'b1; Wr_Addr = 4'd2; Wr_Char = 5'd8;
    edge1();
    Wr_En = 1'b0;
    n_cmp++; if (Seg_Out !== ONES) begin n_bad++; $display("FAIL postreset_latency got=%h want=%h", Seg_Out, ONES); end
    edge1();
    n_cmp++; if (Seg_Out !== {SP, SP, H, SP}) begin n_bad++; $display("FAIL postreset_write got=%h want=%h", Seg_Out, {SP, SP, H, SP}); end
  endtask

  task automatic test_oor_write();
    for (int i = 0; i < 4; i++) begin
      Wr2_En = 1'b1; Wr2_Addr = 4'(i); Wr2_Char = hola[i];
      edge1();
    end
    for (int i = 12; i < 16; i++) begin
      Wr2_En = 1'b1; Wr2_Addr = 4'(i); Wr2_Char = 5'd27;
      edge1();
    end
    Wr2_En = 1'b0;
    edge1();
    n_cmp++; if (Seg2 !== {H, O, L, A}) begin n_bad++; $display("FAIL oor_unchanged got=%h want=%h", Seg2, {H, O, L, A}); end
    // Msg_Len2 = 0 selects the full 12 entries; entry 11 is still a space
    for (int i = 0; i < 11; i++) begin
      Step2 = 1'b1; edge1();
      Step2 = 1'b0; edge1();
    end
    n_cmp++; if (Offset2 !== 4'd11) begin n_bad++; $display("FAIL len0_offset got=%0d want=11", Offset2); end
    n_cmp++; if (Seg2 !== {SP, H, O, L}) begin n_bad++; $display("FAIL len0_seg got=%h want=%h", Seg2, {SP, H, O, L}); end
    Step2 = 1'b1; edge1();
    n_cmp++; if (Offset2 !== 4'd0) begin n_bad++; $display("FAIL len0_wrap_offset got=%0d want=0", Offset2); end
    n_cmp++; if (Wrap2 !== 1'b1) begin n_bad++; $display("FAIL len0_wrap got=%b want=1", Wrap2); end
    Step2 = 1'b0; edge1();
  endtask

  initial begin
    hola[0] = 5'd8; hola[1] = 5'd16; hola[2] = 5'd12; hola[3] = 5'd1;
    rot[0] = {H, O, L, A};
    rot[1] = {O, L, A, H};
    rot[2] = {L, A, H, O};
    rot[3] = {A, H, O, L};
    test_reset();
    test_write_hola();
    test_auto_left();
    test_auto_right();
    test_clamp();
    test_manual();
    test_len_one();
    test_en_reset();
    test_oor_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_scroll_rom.md
# seg_scroll_rom

Parametrised scrolling-message engine for the seven-segment display path: a writable message buffer of character codes, the 32-entry active-low segment character ROM, and an offset sequencer that shifts the message across DIGITS displays automatically or on demand. It sits between the control logic that loads text and the digit drivers. It replaces the single-digit character ROM by driving all digits in parallel, with wrap-around, direction and manual modes.

## Interface
- DIGITS, 4: number of displayed digits, 1..8.
- MSG_LEN, 16: message buffer depth in characters, 2..256.
- TICK_DIV, 50_000_000: clock cycles per automatic scroll step, ≥1.
- AW, derived: clog2(MSG_LEN).

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- En  in  1  low: blank all digits and freeze the sequencer.
- Mode  in  2  scroll mode: 00 auto-left, 01 auto-right, 10 manual, 11 hold.
- Step  in  1  manual step request, synchronous level; a rising edge steps once.
- Msg_Len  in  AW+1  active message length. 0 means MSG_LEN; values above MSG_LEN clamp to MSG_LEN.
- Wr_En  in  1  message buffer write strobe.
- Wr_Addr  in  AW  buffer write address.
- Wr_Char  in  5  character code to write.
- Seg_Out  out  7*DIGITS  active-low segments. Digit 0 (leftmost) is in bits [7*DIGITS-1 -: 7].
- Offset  out  AW  current scroll offset.
- Wrap_Pulse  out  1  one-cycle pulse when the offset wraps.

## Operation
- Character ROM (code → segments gfedcba, active-low):
  - 0 = space (1111111).
  - 1..27 = A..Z with Ñ inserted at 15: A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110, G=0010000, H=0001011, I=1111001, J=1110001, K=0001001, L=1000111, M=1001000, N=0101011, Ñ=0101010, O=1000000, P=0001100, Q=0011000, R=0101111, S=0010010, T=0000111, U=1100011, V=1000001, W=0110000, X=0000101, Y=0010001, Z=0100100.
  - 28..31 = space.
- Effective length: L = clamp(Msg_Len). Digit d shows buffer[(Offset + d) mod L]. When DIGITS > L, characters repeat.
- Tick counter counts 0..TICK_DIV-1 and produces a tick in the cycle it equals TICK_DIV-1, then returns to 0. It runs only when En=1 and Mode is 00 or 01; otherwise it is held at 0.
- Auto-left, on tick: Offset ← (Offset+1) mod L.
- Auto-right, on tick: Offset ← (Offset+L-1) mod L.
- Manual: a Step rising edge (Step=1 and the registered Step=0) sets Offset ← (Offset+1) mod L. The Step register updates in every mode, so a level held across a mode change does not step.
- Hold, or En=0: Offset is frozen.
- Write: when Wr_En=1 and Wr_Addr<MSG_LEN, buffer[Wr_Addr] ← Wr_Char. Out-of-range addresses are ignored. Writes are accepted regardless of En and Mode.
- If Offset ≥ L (after Msg_Len shrinks), Offset ← 0 on the next edge. This clamp has priority over any step and does not pulse Wrap_Pulse.
- Wrap_Pulse is 1 for the cycle after a step moves Offset from L-1 to 0 (left/manual) or from 0 to L-1 (right).

## Timing
- Reset values:
  - Offset = 0
  - tick counter = 0
  - Step register = 0
  - every buffer entry = 0 (space)
  - Seg_Out = all ones
  - Wrap_Pulse = 0
- Seg_Out is registered: it reflects Offset and the buffer as they stand before the edge. It trails an Offset change by 1 cycle and a buffer write by 2 cycles (write edge, then display edge).
- When En=0 is sampled, Seg_Out becomes all ones at that edge. When En returns to 1, real segments appear at the next edge.
- A tick and a Mode change in the same cycle: the tick acts under the Mode sampled that cycle.
- Reset asserted mid-scroll: all state returns to its reset value immediately, asynchronously. Operation resumes on the first edge after release.
- L=1: Offset stays 0, and each step produces Wrap_Pulse.

## Test plan
- Reset, then write "HOLA" (8,16,12,1) to addresses 0..3 with Msg_Len=4, DIGITS=4, TICK_DIV=4, Mode=10, En=1 → Seg_Out = 0001011_1000000_1000111_0001000 two cycles after the last write.
- Mode=00 with the same data → every 4 cycles the digits rotate to OLAH, LAHO, AHOL, HOLA. Wrap_Pulse pulses once, with the fourth step.
- Mode=01 → the first step shows AHOL and Offset=3, with Wrap_Pulse.
- Mode=10 with Step held high for 10 cycles → exactly one step, Offset 0→1.
- Offset=3, then Msg_Len set to 2 → Offset=0 next edge, no Wrap_Pulse, display shows HOHO.
- Mid-scroll: En=0 → Seg_Out all ones and Offset frozen. Pulse reset_n low → Offset=0, buffer all spaces, Seg_Out all ones. Write to Wr_Addr ≥ MSG_LEN → buffer unchanged.
